fpmac_dot_seq: RTL and testbench

//  Dot-product sequencer that drives the FP16 multiply-accumulate unit (fpmac) from its input side and collects its result.

---
 rtl/fpmac_dot_seq_pkg.sv | 38 +++
 rtl/fpmac_lat_cnt.sv | 54 +++++
 rtl/fpmac_dot_seq.sv | 195 +++++++++++++++++++
 tb/tb_fpmac_dot_seq.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpmac_dot_seq_pkg.sv
// ---------------------------------------------------------------------------
// fpmac_dot_seq_pkg
//   Shared definitions for clients of the FP16 multiply-accumulate unit
//   (fpmac): FP16 constants, the sequencer state encoding and the default
//   fpmac pipeline latency.
// ---------------------------------------------------------------------------
package fpmac_dot_seq_pkg;

  // FP16 positive zero; also the accumulator seed for a new vector.
  localparam logic [15:0] FP16_ZERO = 16'h0000;

  // Value fpmac produces when a result overflows.  The sequencer feeds it
  // back unchanged, so it is listed here for clients and checkers.
  localparam logic [15:0] FP16_SAT  = 16'hFC00;

  // Rising edges from the edge that registers mac_* to the edge after which
  // fpmac.out holds the corresponding result.
  localparam int MAC_LAT_DEF = 11;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } seq_state_e;

  // Saturating increment for an 8-bit element counter; held at all-ones.
  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    logic [7:0] res;
    if (val == 8'hFF) begin
      res = val;
    end else begin
      res = val + 8'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/fpmac_lat_cnt.sv
// ---------------------------------------------------------------------------
// fpmac_lat_cnt
//   Latency down-counter for fpmac clients.  A load pulse starts the count at
//   LAT; the counter then decrements once per edge and raises done while it
//   sits at zero.  done is high for exactly one cycle per load, on the cycle
//   whose closing edge is the (LAT+1)-th edge after the load edge, i.e. the
//   first edge at which fpmac.out already holds the issued result.
//
// Ports
//   CLK   in   clock, rising edge
//   RST   in   asynchronous active-low reset; clears any count in progress
//   load  in   issue strobe (sampled at the rising edge)
//   done  out  one-cycle "result available" strobe, derived only from flops
// ---------------------------------------------------------------------------
module fpmac_lat_cnt
  import fpmac_dot_seq_pkg::*;
#(
  parameter int LAT = MAC_LAT_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic load,
  output logic done
);

  localparam int W = $clog2(LAT + 1);

  logic [W-1:0] cnt_r;
  logic         busy_r;

  // Count register: reload on issue, walk down to zero, then go idle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_r  <= {W{1'b0}};
      busy_r <= 1'b0;
    end else if (load) begin
      cnt_r  <= W'(LAT);
      busy_r <= 1'b1;
    end else if (busy_r) begin
      if (cnt_r == {W{1'b0}}) begin
        busy_r <= 1'b0;
      end else begin
        cnt_r <= cnt_r - W'(1);
      end
    end else begin
      cnt_r  <= cnt_r;
      busy_r <= busy_r;
    end
  end

  // Busy and at zero: this cycle's closing edge may sample fpmac.out.
  assign done = busy_r && (cnt_r == {W{1'b0}});

endmodule

// File: rtl/fpmac_dot_seq.sv
// ---------------------------------------------------------------------------
// fpmac_dot_seq
//   Dot-product sequencer in front of the FP16 multiply-accumulate unit.
//   Accepts (activation, weight) pairs from an upstream valid/ready stream,
//   issues one pair at a time to fpmac as a single-cycle pulse on
//   mac_in/mac_weight/mac_acc, waits for the fixed fpmac latency, feeds the
//   result back as the accumulator of the next element and, after the element
//   flagged s_last, presents the FP16 sum on a downstream valid/ready port.
//   No FP arithmetic is done here; fpmac results (including its saturated
//   overflow value) are passed along untouched.  Only one element is ever in
//   flight inside fpmac, so throughput is one element per MAC_LAT+2 cycles.
//
// Configuration macro
//   FPMAC_SEQ_STICKY_EN  defined:   m_overflow/m_sub are the OR of the flags
//                                   of every element of the vector, cleared
//                                   when the result is taken.
//                        undefined: m_overflow/m_sub are the flags returned
//                                   with the last element only.
//
// Ports
//   CLK, RST                  clock (rising edge), async active-low reset
//   s_valid/s_ready           upstream element handshake
//   s_in, s_weight, s_last    FP16 activation, FP16 weight, end-of-vector
//   mac_in/mac_weight/mac_acc registered operands to fpmac
//   mac_out/mac_overflow/
//   mac_sub                   result and flags from fpmac
//   m_valid/m_ready           downstream result handshake
//   m_data, m_overflow, m_sub FP16 dot product and its flags
//   m_len                     elements in the vector, saturating at all-ones
// ---------------------------------------------------------------------------
module fpmac_dot_seq
  import fpmac_dot_seq_pkg::*;
#(
  parameter int MAC_LAT = MAC_LAT_DEF,
  parameter int CNT_W   = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [15:0]      s_in,
  input  logic [15:0]      s_weight,
  input  logic             s_last,
  output logic [15:0]      mac_in,
  output logic [15:0]      mac_weight,
  output logic [15:0]      mac_acc,
  input  logic [15:0]      mac_out,
  input  logic             mac_overflow,
  input  logic             mac_sub,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [15:0]      m_data,
  output logic             m_overflow,
  output logic             m_sub,
  output logic [CNT_W-1:0] m_len
);

  seq_state_e       state_r;
  logic             s_ready_r;
  logic             first_r;
  logic             last_r;
  logic             m_valid_r;
  logic             ovf_r;
  logic             sub_r;
  logic [15:0]      mac_in_r;
  logic [15:0]      mac_weight_r;
  logic [15:0]      mac_acc_r;
  logic [15:0]      acc_r;
  logic [15:0]      m_data_r;
  logic [CNT_W-1:0] m_len_r;
  logic             issue_s;
  logic             done_s;

  // An element is taken only in IDLE with the ready flop already up, so a
  // held s_valid can never cause a second issue while a result is pending.
  assign issue_s = (state_r == ST_IDLE) && s_ready_r && s_valid;

  fpmac_lat_cnt #(
    .LAT (MAC_LAT)
  ) u_lat_cnt (
    .CLK  (CLK),
    .RST  (RST),
    .load (issue_s),
    .done (done_s)
  );

  // Sequencer FSM with all outputs registered.  s_ready is a flop that is
  // low in reset and rises on the first edge after release.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r      <= ST_IDLE;
      s_ready_r    <= 1'b0;
      first_r      <= 1'b1;
      last_r       <= 1'b0;
      m_valid_r    <= 1'b0;
      ovf_r        <= 1'b0;
      sub_r        <= 1'b0;
      mac_in_r     <= FP16_ZERO;
      mac_weight_r <= FP16_ZERO;
      mac_acc_r    <= FP16_ZERO;
      acc_r        <= FP16_ZERO;
      m_data_r     <= FP16_ZERO;
      m_len_r      <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (issue_s) begin
            mac_in_r     <= s_in;
            mac_weight_r <= s_weight;
            // The first element of a vector starts from zero rather than
            // whatever the previous vector left behind.
            mac_acc_r    <= first_r ? FP16_ZERO : acc_r;
            last_r       <= s_last;
            first_r      <= 1'b0;
            if (m_len_r != {CNT_W{1'b1}}) begin
              m_len_r <= m_len_r + CNT_W'(1);
            end else begin
              m_len_r <= m_len_r;
            end
            s_ready_r    <= 1'b0;
            state_r      <= ST_WAIT;
          end else begin
            s_ready_r    <= 1'b1;
          end
        end

        ST_WAIT: begin
          // Operands are a one-cycle pulse; fpmac has already captured them.
          mac_in_r     <= FP16_ZERO;
          mac_weight_r <= FP16_ZERO;
          mac_acc_r    <= FP16_ZERO;
          if (done_s) begin
            acc_r <= mac_out;
`ifdef FPMAC_SEQ_STICKY_EN
            ovf_r <= ovf_r | mac_overflow;
            sub_r <= sub_r | mac_sub;
`else
            ovf_r <= mac_overflow;
            sub_r <= mac_sub;
`endif
            if (last_r) begin
              m_valid_r <= 1'b1;
              m_data_r  <= mac_out;
              state_r   <= ST_HOLD;
            end else begin
              s_ready_r <= 1'b1;
              state_r   <= ST_IDLE;
            end
          end else begin
            state_r <= ST_WAIT;
          end
        end

        ST_HOLD: begin
          if (m_ready) begin
            m_valid_r <= 1'b0;
            first_r   <= 1'b1;
            m_len_r   <= {CNT_W{1'b0}};
            acc_r     <= FP16_ZERO;
`ifdef FPMAC_SEQ_STICKY_EN
            ovf_r     <= 1'b0;
            sub_r     <= 1'b0;
`endif
            s_ready_r <= 1'b1;
            state_r   <= ST_IDLE;
          end else begin
            state_r   <= ST_HOLD;
          end
        end

        default: begin
          // Unreachable encoding: park safely with nothing issued or valid.
          state_r      <= ST_IDLE;
          s_ready_r    <= 1'b0;
          m_valid_r    <= 1'b0;
          first_r      <= 1'b1;
          mac_in_r     <= FP16_ZERO;
          mac_weight_r <= FP16_ZERO;
          mac_acc_r    <= FP16_ZERO;
        end
      endcase
    end
  end

  assign s_ready    = s_ready_r;
  assign mac_in     = mac_in_r;
  assign mac_weight = mac_weight_r;
  assign mac_acc    = mac_acc_r;
  assign m_valid    = m_valid_r;
  assign m_data     = m_data_r;
  assign m_overflow = ovf_r;
  assign m_sub      = sub_r;
  assign m_len      = m_len_r;

endmodule

// File: tb/tb_fpmac_dot_seq.sv
// ---------------------------------------------------------------------------
// tb_fpmac_dot_seq
//   Bench for fpmac_dot_seq.  A behavioural fpmac (real-number multiply-add
//   rounded to FP16, MAC_LAT-stage delay) sits on the mac_* side; expected
//   sums, flags and lengths come from a reference walk over each vector.
// ---------------------------------------------------------------------------
module tb_fpmac_dot_seq;

  localparam int MAC_LAT = 11;
  localparam int CNT_W   = 8;

  logic             CLK;
  logic             RST;
  logic             s_valid;
  logic             s_ready;
  logic [15:0]      s_in;
  logic [15:0]      s_weight;
  logic             s_last;
  logic [15:0]      mac_in;
  logic [15:0]      mac_weight;
  logic [15:0]      mac_acc;
  logic [15:0]      mac_out;
  logic             mac_overflow;
  logic             mac_sub;
  logic             m_valid;
  logic             m_ready;
  logic [15:0]      m_data;
  logic             m_overflow;
  logic             m_sub;
  logic [CNT_W-1:0] m_len;

  int n_cmp;
  int n_bad;
  int cyc;

  logic [15:0] vin [300];
  logic [15:0] vw  [300];

`ifdef FPMAC_SEQ_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  fpmac_dot_seq #(.MAC_LAT(MAC_LAT), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST),
    .s_valid(s_valid), .s_ready(s_ready), .s_in(s_in), .s_weight(s_weight), .s_last(s_last),
    .mac_in(mac_in), .mac_weight(mac_weight), .mac_acc(mac_acc),
    .mac_out(mac_out), .mac_overflow(mac_overflow), .mac_sub(mac_sub),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_overflow(m_overflow), .m_sub(m_sub), .m_len(m_len)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc = cyc + 1;

  // ---------------- FP16 reference arithmetic ----------------
  function automatic real pow2(input int k);
    real p;
    p = 1.0;
    if (k >= 0) for (int i = 0; i < k; i++) p = p * 2.0;
    else        for (int i = 0; i < -k; i++) p = p / 2.0;
    return p;
  endfunction

  function automatic real fp16_to_real(input logic [15:0] h);
    real v;
    int e, m;
    e = int'(h[14:10]);
    m = int'(h[9:0]);
    if (e == 0)       v = real'(m) * pow2(-24);
    else if (e == 31) v = 65536.0;
    else              v = real'(1024 + m) * pow2(e - 25);
    return h[15] ? -v : v;
  endfunction

  // Returns {overflow, subnormal_or_zero, fp16}; round to nearest even.
  function automatic logic [17:0] real_to_fp16(input real r);
    logic s;
    real a, m, fr;
    int e, mi;
    s = (r < 0.0);
    a = s ? -r : r;
    if (a == 0.0) return {2'b01, 16'h0000};
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    if (e < -14) m = a * pow2(e + 24);
    else         m = a * 1024.0;
    mi = $rtoi(m);
    fr = m - real'(mi);
    if (fr > 0.5 || (fr == 0.5 && (mi % 2) == 1)) mi++;
    if (e < -14) begin
      if (mi == 0) return {2'b01, 16'h0000};
      return {1'b0, (mi < 1024), s, 15'(mi)};
    end
    if (mi == 2048) begin mi = 1024; e++; end
    if (e > 15) return {2'b10, 16'hFC00};
    return {2'b00, s, 5'(e + 15), 10'(mi - 1024)};
  endfunction

  function automatic logic [17:0] fma16(input logic [15:0] a, input logic [15:0] w,
                                        input logic [15:0] c);
    return real_to_fp16(fp16_to_real(a) * fp16_to_real(w) + fp16_to_real(c));
  endfunction

  // ---------------- behavioural fpmac ----------------
  logic [17:0] pipe [MAC_LAT];
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < MAC_LAT; i++) pipe[i] <= 18'h0;
    end else begin
      pipe[0] <= fma16(mac_in, mac_weight, mac_acc);
      for (int i = 1; i < MAC_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign mac_out      = pipe[MAC_LAT-1][15:0];
  assign mac_overflow = pipe[MAC_LAT-1][17];
  assign mac_sub      = pipe[MAC_LAT-1][16];

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [15:0] a, input logic [15:0] w, input logic last,
                      output bit ok, output int t_acc);
    @(negedge CLK);
    s_valid = 1'b1; s_in = a; s_weight = w; s_last = last;
    ok = 1'b0; t_acc = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (s_ready === 1'b1) ok = 1'b1;
      else @(negedge CLK);
    end
    if (ok) begin
      @(posedge CLK); #1;
      t_acc = cyc;
    end
    s_valid = 1'b0; s_in = 16'($urandom); s_weight = 16'($urandom); s_last = 1'($urandom);
  endtask

  // Sends vin/vw[0..n-1], checks issues, the result and the hold behaviour.
  task automatic run_vector(input int n, input int hold, input string tag,
                            output logic [15:0] d, output logic o, output logic su,
                            output logic [CNT_W-1:0] ln);
    logic [17:0]      r;
    logic [15:0]      acc;
    logic             eo, es;
    logic [CNT_W-1:0] elen;
    int               t0, t, wt;
    bit               ok;
    acc = 16'h0000; eo = 1'b0; es = 1'b0; t0 = 0; wt = 0;
    d = 16'h0000; o = 1'b0; su = 1'b0; ln = '0;
    elen = (n > 255) ? 8'hFF : CNT_W'(n);
    for (int k = 0; k < n; k++) begin
      send(vin[k], vw[k], (k == n - 1), ok, t);
      n_cmp++;
      if (!ok) begin
        n_bad++;
        $display("FAIL %s accept[%0d]: s_ready=%b, required 1 within 100 cycles", tag, k, s_ready);
        return;
      end
      t0 = t;
      if (mac_in !== vin[k] || mac_weight !== vw[k] || mac_acc !== acc) begin
        n_bad++;
        $display("FAIL %s issue[%0d]: got %h/%h/%h required %h/%h/%h", tag, k,
                 mac_in, mac_weight, mac_acc, vin[k], vw[k], acc);
      end
      r = fma16(vin[k], vw[k], acc);
      acc = r[15:0];
      if (STICKY) begin eo = eo | r[17]; es = es | r[16]; end
      else        begin eo = r[17];      es = r[16];      end
      @(posedge CLK); #1;
      n_cmp++;
      if ({mac_in, mac_weight, mac_acc} !== 48'h0) begin
        n_bad++;
        $display("FAIL %s pulse[%0d]: mac_*=%h/%h/%h required 0", tag, k, mac_in, mac_weight, mac_acc);
      end
    end
    @(negedge CLK);
    while (m_valid !== 1'b1 && wt < 64) begin @(negedge CLK); wt++; end
    n_cmp++;
    if (m_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL %s m_valid: got %b required 1 within 64 cycles", tag, m_valid);
      return;
    end
    n_cmp++;
    if (cyc - t0 != MAC_LAT + 1) begin
      n_bad++;
      $display("FAIL %s latency: got %0d edges required %0d", tag, cyc - t0, MAC_LAT + 1);
    end
    d = m_data; o = m_overflow; su = m_sub; ln = m_len;
    n_cmp++;
    if (m_data !== acc || m_overflow !== eo || m_sub !== es || m_len !== elen || s_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL %s result: got d=%h o=%b s=%b len=%0d rdy=%b required d=%h o=%b s=%b len=%0d rdy=0",
               tag, m_data, m_overflow, m_sub, m_len, s_ready, acc, eo, es, elen);
    end
    for (int h = 0; h < hold; h++) begin
      s_valid = 1'b1; s_in = 16'($urandom); s_weight = 16'($urandom); s_last = 1'b1;
      @(negedge CLK);
      n_cmp++;
      if (m_valid !== 1'b1 || m_data !== acc || m_len !== elen || m_overflow !== eo ||
          m_sub !== es || s_ready !== 1'b0 || mac_in !== 16'h0000) begin
        n_bad++;
        $display("FAIL %s hold[%0d]: got v=%b d=%h len=%0d rdy=%b mac_in=%h required v=1 d=%h len=%0d rdy=0 mac_in=0000",
                 tag, h, m_valid, m_data, m_len, s_ready, mac_in, acc, elen);
      end
    end
    m_ready = 1'b1;
    @(posedge CLK); #1;
    m_ready = 1'b0; s_valid = 1'b0;
    n_cmp++;
    if (m_valid !== 1'b0 || m_len !== '0) begin
      n_bad++;
      $display("FAIL %s release: got v=%b len=%0d required v=0 len=0", tag, m_valid, m_len);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RST = 1'b0; s_valid = 1'b1; s_in = 16'h3C00; s_weight = 16'h3C00; s_last = 1'b1; m_ready = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    n_cmp++;
    if (s_ready !== 1'b0 || m_valid !== 1'b0 || m_data !== 16'h0 || m_len !== '0 ||
        m_overflow !== 1'b0 || m_sub !== 1'b0 || {mac_in, mac_weight, mac_acc} !== 48'h0) begin
      n_bad++;
      $display("FAIL reset_state: got rdy=%b v=%b d=%h len=%0d mac=%h/%h/%h required all 0",
               s_ready, m_valid, m_data, m_len, mac_in, mac_weight, mac_acc);
    end
    s_valid = 1'b0;
    @(negedge CLK); RST = 1'b1;
    @(posedge CLK); #1;
    n_cmp++;
    if (s_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release: s_ready=%b required 1", s_ready);
    end
  endtask

  task automatic test_single();
    logic [15:0] d; logic o, su; logic [CNT_W-1:0] ln;
    vin[0] = 16'h3C00; vw[0] = 16'h4000;
    run_vector(1, 0, "single", d, o, su, ln);
    n_cmp++;
    if (d !== 16'h4000 || ln !== 8'd1 || o !== 1'b0 || su !== 1'b0) begin
      n_bad++;
      $display("FAIL single_const: got d=%h len=%0d o=%b s=%b required 4000 1 0 0", d, ln, o, su);
    end
  endtask

  task automatic test_vector3();
    logic [15:0] d; logic o, su; logic [CNT_W-1:0] ln;
    vin[0] = 16'h3C00; vw[0] = 16'h4000;
    vin[1] = 16'h4000; vw[1] = 16'h4000;
    vin[2] = 16'h4200; vw[2] = 16'h3C00;
    run_vector(3, 0, "vec3", d, o, su, ln);
    n_cmp++;
    if (d !== 16'h4880 || ln !== 8'd3) begin
      n_bad++;
      $display("FAIL vec3_const: got d=%h len=%0d required 4880 3", d, ln);
    end
  endtask

  task automatic test_back_pressure();
    logic [15:0] d; logic o, su; logic [CNT_W-1:0] ln;
    vin[0] = 16'h4000; vw[0] = 16'h4200;
    run_vector(1, 5, "hold", d, o, su, ln);
  endtask

  task automatic test_overflow();
    logic [15:0] d; logic o, su; logic [CNT_W-1:0] ln;
    vin[0] = 16'h7BFF; vw[0] = 16'h7BFF;
    run_vector(1, 1, "ovf", d, o, su, ln);
    n_cmp++;
    if (d !== 16'hFC00 || o !== 1'b1 || su !== 1'b0) begin
      n_bad++;
      $display("FAIL ovf_const: got d=%h o=%b s=%b required FC00 1 0", d, o, su);
    end
  endtask

  task automatic test_sub_flag();
    logic [15:0] d; logic o, su; logic [CNT_W-1:0] ln;
    vin[0] = 16'h0400; vw[0] = 16'h0400;
    vin[1] = 16'h3C00; vw[1] = 16'h3C00;
    run_vector(2, 0, "sub", d, o, su, ln);
    n_cmp++;
    if (d !== 16'h3C00 || su !== STICKY || o !== 1'b0) begin
      n_bad++;
      $display("FAIL sub_const: got d=%h s=%b o=%b required 3C00 %b 0", d, su, o, STICKY);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] d; logic o, su; logic [CNT_W-1:0] ln;
    bit ok; int t;
    send(16'h3C00, 16'h4000, 1'b0, ok, t);
    send(16'h4000, 16'h4000, 1'b0, ok, t);
    n_cmp++;
    if (!ok || mac_acc !== 16'h4000) begin
      n_bad++;
      $display("FAIL rstmid_issue2: got ok=%b mac_acc=%h required 1 4000", ok, mac_acc);
    end
    repeat (3) @(posedge CLK);
    #2; RST = 1'b0; #1;
    n_cmp++;
    if (s_ready !== 1'b0 || m_valid !== 1'b0 || m_data !== 16'h0 || m_len !== '0 ||
        m_overflow !== 1'b0 || m_sub !== 1'b0 || {mac_in, mac_weight, mac_acc} !== 48'h0) begin
      n_bad++;
      $display("FAIL rstmid_async: got rdy=%b v=%b d=%h len=%0d mac=%h/%h/%h required all 0",
               s_ready, m_valid, m_data, m_len, mac_in, mac_weight, mac_acc);
    end
    @(negedge CLK); @(negedge CLK); RST = 1'b1;
    vin[0] = 16'h3C00; vw[0] = 16'h3C00;
    run_vector(1, 0, "rstmid", d, o, su, ln);
    n_cmp++;
    if (d !== 16'h3C00 || ln !== 8'd1) begin
      n_bad++;
      $display("FAIL rstmid_const: got d=%h len=%0d required 3C00 1", d, ln);
    end
  endtask

  task automatic test_len_sat();
    logic [15:0] d; logic o, su; logic [CNT_W-1:0] ln;
    for (int k = 0; k < 260; k++) begin vin[k] = 16'h0000; vw[k] = 16'h0000; end
    run_vector(260, 0, "lensat", d, o, su, ln);
    n_cmp++;
    if (ln !== 8'hFF || d !== 16'h0000 || su !== 1'b1) begin
      n_bad++;
      $display("FAIL lensat_const: got len=%0d d=%h s=%b required 255 0000 1", ln, d, su);
    end
  endtask

  task automatic test_random();
    logic [15:0] d; logic o, su; logic [CNT_W-1:0] ln;
    int n;
    for (int v = 0; v < 20; v++) begin
      n = $urandom_range(1, 5);
      for (int k = 0; k < n; k++) begin
        vin[k] = {1'($urandom_range(0, 1)), 5'($urandom_range(12, 16)), 10'($urandom)};
        vw[k]  = {1'($urandom_range(0, 1)), 5'($urandom_range(12, 16)), 10'($urandom)};
      end
      run_vector(n, $urandom_range(0, 3), "random", d, o, su, ln);
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0;
    RST = 1'b0; s_valid = 1'b0; s_in = 16'h0; s_weight = 16'h0; s_last = 1'b0; m_ready = 1'b0;
    test_reset();
    test_single();
    test_vector3();
    test_back_pressure();
    test_overflow();
    test_sub_flag();
    test_reset_mid();
    test_len_sat();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached after %0d cycles", cyc);
    $fatal(1, "watchdog");
  end

endmodule
